kbd_frame_rx: RTL and testbench

Keyboard serial-frame receiver and scan-code sequencer for EksBox. Takes the raw asynchronous SCLK/SDATA pins and synchronizes them internally. It detects SCLK falling edges, assembles 11-bit frames (start, 8 data LSB-first, odd parity, stop) and checks them. It folds the 0xE0/0xF0 prefix codes into flags on the following code, so game logic sees one `VALID` pulse per key event.

---
 rtl/kbd_pkg.sv | 16 +
 rtl/kbd_edge_sync.sv | 40 ++++
 rtl/kbd_frame_rx.sv | 190 +++++++++++++++++++
 tb/tb_kbd_frame_rx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and constants for the keyboard frame receiver.
// Receiver state enum, prefix scan codes and the default frame timeout.
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } kbd_state_e;

  localparam logic [7:0] KBD_PFX_EXT     = 8'hE0;
  localparam logic [7:0] KBD_PFX_REL     = 8'hF0;
  localparam int         KBD_TIMEOUT_CYC = 100000;

endpackage

// File: rtl/kbd_edge_sync.sv
// kbd_edge_sync: two-flop synchronizers for the raw keyboard SCLK/SDATA pins
// plus a falling-edge strobe on the synchronized clock.
module kbd_edge_sync (
  input  logic i_clk,
  input  logic i_aclr_l,
  input  logic i_sclk,
  input  logic i_sdata,
  output logic o_sdata,
  output logic o_fall
);

  logic r_sclk_meta;
  logic r_sclk_sync;
  logic r_sclk_prev;
  logic r_sdata_meta;
  logic r_sdata_sync;

  // Bring both pins into the clk domain and keep one cycle of SCLK history.
  always_ff @(posedge i_clk or negedge i_aclr_l) begin
    if (!i_aclr_l) begin
      r_sclk_meta  <= 1'b0;
      r_sclk_sync  <= 1'b0;
      r_sclk_prev  <= 1'b0;
      r_sdata_meta <= 1'b0;
      r_sdata_sync <= 1'b0;
    end else begin
      r_sclk_meta  <= i_sclk;
      r_sclk_sync  <= r_sclk_meta;
      r_sclk_prev  <= r_sclk_sync;
      r_sdata_meta <= i_sdata;
      r_sdata_sync <= r_sdata_meta;
    end
  end

  // Reset clears the history to 0, so an idle-high SCLK after reset never
  // looks like a falling edge.
  assign o_sdata = r_sdata_sync;
  assign o_fall  = r_sclk_prev & ~r_sclk_sync;

endmodule

// File: rtl/kbd_frame_rx.sv
// kbd_frame_rx: keyboard 11-bit frame receiver and scan-code sequencer.
// Folds 0xE0 / 0xF0 prefixes into KEY_EXT / KEY_REL flags on the next code.
// Optional frame timeout is built only when KBD_TIMEOUT_EN is defined.
module kbd_frame_rx
  import kbd_pkg::*;
`ifdef KBD_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYC = KBD_TIMEOUT_CYC
)
`endif
(
  input  logic       i_clk,
  input  logic       i_aclr_l,
  input  logic       i_sclk,
  input  logic       i_sdata,
  output logic [7:0] o_data,
  output logic       o_key_rel,
  output logic       o_key_ext,
  output logic       o_valid,
  output logic       o_perr,
  output logic       o_ferr
);

  kbd_state_e r_state;
  kbd_state_e w_state_nxt;

  logic       w_sdata;
  logic       w_fall;
  logic       w_timeout;

  logic [2:0] r_cnt;
  logic [7:0] r_shift;
  logic       r_par;
  logic       r_ext_pend;
  logic       r_rel_pend;

  logic       w_valid_nxt;
  logic       w_perr_nxt;
  logic       w_ferr_nxt;
  logic       w_load;
  logic       w_set_ext;
  logic       w_set_rel;
  logic       w_clr_pend;

  kbd_edge_sync u_edge_sync (
    .i_clk    (i_clk),
    .i_aclr_l (i_aclr_l),
    .i_sclk   (i_sclk),
    .i_sdata  (i_sdata),
    .o_sdata  (w_sdata),
    .o_fall   (w_fall)
  );

`ifdef KBD_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] r_to_cnt;

  // Cycles since the last SCLK fall while a frame is in progress.
  always_ff @(posedge i_clk or negedge i_aclr_l) begin
    if (!i_aclr_l) begin
      r_to_cnt <= '0;
    end else if (w_fall) begin
      r_to_cnt <= '0;
    end else if ((r_state != ST_IDLE) && !w_timeout) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_aclr_l) begin
    if (!i_aclr_l) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: advance one bit per SCLK fall; a fall beats a timeout.
  always_comb begin
    w_state_nxt = r_state;
    if (w_fall) begin
      case (r_state)
        ST_IDLE:   if (!w_sdata) w_state_nxt = ST_DATA;
        ST_DATA:   if (r_cnt == 3'd7) w_state_nxt = ST_PARITY;
        ST_PARITY: w_state_nxt = ST_STOP;
        ST_STOP:   w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Frame evaluation on the stop-bit fall: framing, then parity, then accept.
  always_comb begin
    w_valid_nxt = 1'b0;
    w_perr_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_load      = 1'b0;
    w_set_ext   = 1'b0;
    w_set_rel   = 1'b0;
    w_clr_pend  = 1'b0;
    if (w_fall && (r_state == ST_STOP)) begin
      if (!w_sdata) begin
        w_ferr_nxt = 1'b1;
        w_clr_pend = 1'b1;
      end else if (!(^{r_shift, r_par})) begin
        w_perr_nxt = 1'b1;
        w_clr_pend = 1'b1;
      end else if (r_shift == KBD_PFX_EXT) begin
        w_set_ext = 1'b1;
      end else if (r_shift == KBD_PFX_REL) begin
        w_set_rel = 1'b1;
      end else begin
        w_load      = 1'b1;
        w_valid_nxt = 1'b1;
        w_clr_pend  = 1'b1;
      end
    end else if (!w_fall && w_timeout) begin
      w_ferr_nxt = 1'b1;
      w_clr_pend = 1'b1;
    end
  end

  // Bit counter, data shift register and parity latch.
  always_ff @(posedge i_clk or negedge i_aclr_l) begin
    if (!i_aclr_l) begin
      r_cnt   <= 3'd0;
      r_shift <= 8'd0;
      r_par   <= 1'b0;
    end else if (w_fall) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_sdata) r_cnt <= 3'd0;
        end
        ST_DATA: begin
          r_shift[r_cnt] <= w_sdata;
          r_cnt          <= r_cnt + 3'd1;
        end
        ST_PARITY: begin
          r_par <= w_sdata;
        end
        default: ;
      endcase
    end
  end

  // Prefix flags wait for the next real scan code; errors drop them.
  always_ff @(posedge i_clk or negedge i_aclr_l) begin
    if (!i_aclr_l) begin
      r_ext_pend <= 1'b0;
      r_rel_pend <= 1'b0;
    end else if (w_clr_pend) begin
      r_ext_pend <= 1'b0;
      r_rel_pend <= 1'b0;
    end else begin
      if (w_set_ext) r_ext_pend <= 1'b1;
      if (w_set_rel) r_rel_pend <= 1'b1;
    end
  end

  // Output registers: pulses every cycle, key fields only on acceptance.
  always_ff @(posedge i_clk or negedge i_aclr_l) begin
    if (!i_aclr_l) begin
      o_data    <= 8'd0;
      o_key_rel <= 1'b0;
      o_key_ext <= 1'b0;
      o_valid   <= 1'b0;
      o_perr    <= 1'b0;
      o_ferr    <= 1'b0;
    end else begin
      o_valid <= w_valid_nxt;
      o_perr  <= w_perr_nxt;
      o_ferr  <= w_ferr_nxt;
      if (w_load) begin
        o_data    <= r_shift;
        o_key_rel <= r_rel_pend;
        o_key_ext <= r_ext_pend;
      end
    end
  end

endmodule

// File: tb/tb_kbd_frame_rx.sv
// tb_kbd_frame_rx: scoreboard bench for kbd_frame_rx. Frames are driven on the
// raw pins; a key-event model queues expected pulses, a negedge monitor checks.
// Build with KBD_TIMEOUT_EN defined to also exercise the frame timeout.
module tb_kbd_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk;
  logic       sdata;
  logic [7:0] o_data;
  logic       o_key_rel;
  logic       o_key_ext;
  logic       o_valid;
  logic       o_perr;
  logic       o_ferr;

  always #5 clk = ~clk;

`ifdef KBD_TIMEOUT_EN
  localparam int TB_TO = 200;
  kbd_frame_rx #(.TIMEOUT_CYC(TB_TO)) dut (
`else
  kbd_frame_rx dut (
`endif
    .i_clk     (clk),
    .i_aclr_l  (rst_n),
    .i_sclk    (sclk),
    .i_sdata   (sdata),
    .o_data    (o_data),
    .o_key_rel (o_key_rel),
    .o_key_ext (o_key_ext),
    .o_valid   (o_valid),
    .o_perr    (o_perr),
    .o_ferr    (o_ferr)
  );

  localparam logic [2:0] K_VALID = 3'b100;
  localparam logic [2:0] K_PERR  = 3'b010;
  localparam logic [2:0] K_FERR  = 3'b001;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    logic       rel;
    logic       ext;
    longint     due;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  longint     cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         half_per = 4;
  bit         m_rel = 1'b0;
  bit         m_ext = 1'b0;
  logic [7:0] m_last = 8'd0;
  int         req_id = 0;
  int         ack_id = 0;
  logic [7:0] req_data = 8'd0;
  bit         tb_done = 1'b0;
  logic [7:0] last_data = 8'd0;
  logic       last_rel = 1'b0;
  logic       last_ext = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [2:0] k, input logic [7:0] d, input logic r,
                      input logic e, input longint due);
    exp_t x;
    x.kind = k;
    x.data = d;
    x.rel  = r;
    x.ext  = e;
    x.due  = due;
    exp_q.push_back(x);
  endtask

  // Key-event model: what a game sees for one complete frame.
  task automatic model_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok,
                             input longint due);
    if (!stop_ok) begin
      push(K_FERR, 8'd0, 1'b0, 1'b0, due);
      m_rel = 1'b0;
      m_ext = 1'b0;
    end else if (!par_ok) begin
      push(K_PERR, 8'd0, 1'b0, 1'b0, due);
      m_rel = 1'b0;
      m_ext = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else begin
      push(K_VALID, b, m_rel, m_ext, due);
      m_last = b;
      m_rel  = 1'b0;
      m_ext  = 1'b0;
    end
  endtask

  // Drive the first nbits of a frame; SCLK idles high, data changes while high.
  task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop_bad,
                            input int nbits, input bit hold_low);
    logic [10:0] bits;
    bits[0]    = 1'b0;
    bits[8:1]  = b;
    bits[9]    = ~(^b) ^ par_flip;
    bits[10]   = ~stop_bad;
    for (int i = 0; i < nbits; i++) begin
      sdata = bits[i];
      tick(half_per);
      sclk = 1'b0;
      if (i == 10) model_frame(b, !par_flip, !stop_bad, cyc + 3);
      tick(half_per);
      if (!(hold_low && (i == nbits - 1))) sclk = 1'b1;
    end
    sdata = 1'b1;
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11, 1'b0);
    tick(6);
  endtask

  task automatic check_data(input logic [7:0] d);
    req_data = d;
    req_id   = req_id + 1;
    tick(2);
  endtask

  // Monitor: pops the scoreboard on every pulse and guards the held outputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      checks++;
      if ({o_data, o_key_rel, o_key_ext, o_valid, o_perr, o_ferr} != 13'd0) begin
        errors++;
        $display("FAIL reset_outputs: got data=%h rel=%b ext=%b vpf=%b%b%b, need all 0",
                 o_data, o_key_rel, o_key_ext, o_valid, o_perr, o_ferr);
      end
      last_data = 8'd0;
      last_rel  = 1'b0;
      last_ext  = 1'b0;
    end else begin
      if (o_valid || o_perr || o_ferr) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got vpf=%b%b%b data=%h at cycle %0d, need no pulse",
                   o_valid, o_perr, o_ferr, o_data, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (({o_valid, o_perr, o_ferr} != mon_e.kind) ||
              ((mon_e.kind == K_VALID) &&
               ({o_data, o_key_rel, o_key_ext} != {mon_e.data, mon_e.rel, mon_e.ext})) ||
              ((mon_e.due >= 0) && (mon_e.due != cyc))) begin
            errors++;
            $display("FAIL event: got vpf=%b%b%b data=%h rel=%b ext=%b cyc=%0d, need vpf=%b data=%h rel=%b ext=%b cyc=%0d",
                     o_valid, o_perr, o_ferr, o_data, o_key_rel, o_key_ext, cyc,
                     mon_e.kind, mon_e.data, mon_e.rel, mon_e.ext, mon_e.due);
          end
        end
      end
      if (!o_valid) begin
        checks++;
        if ({o_data, o_key_rel, o_key_ext} != {last_data, last_rel, last_ext}) begin
          errors++;
          $display("FAIL hold: got data=%h rel=%b ext=%b without VALID, need data=%h rel=%b ext=%b",
                   o_data, o_key_rel, o_key_ext, last_data, last_rel, last_ext);
        end
      end
      last_data = o_data;
      last_rel  = o_key_rel;
      last_ext  = o_key_ext;
      if (req_id != ack_id) begin
        checks++;
        if (o_data != req_data) begin
          errors++;
          $display("FAIL data_held: got data=%h, need %h", o_data, req_data);
        end
        ack_id = req_id;
      end
      if (tb_done) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL drain: %0d expected events never seen, need 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  initial begin
    int pfx;
    int err;
    logic [7:0] b;
    rst_n = 1'b0;
    sclk  = 1'b1;
    sdata = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(5);

    // Plain make code, then release and a second make.
    good(8'h1C);
    good(8'hF0);
    good(8'h1C);
    good(8'h1C);
    // Extended release accumulates both prefixes.
    good(8'hE0);
    good(8'hF0);
    good(8'h75);
    // Parity and stop errors leave DATA alone.
    send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b0);
    tick(6);
    check_data(8'h75);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    tick(6);
    check_data(8'h75);
    // A prefix followed by an error frame is forgotten.
    good(8'hF0);
    send_frame(8'h12, 1'b1, 1'b0, 11, 1'b0);
    tick(6);
    good(8'h12);

`ifdef KBD_TIMEOUT_EN
    // Stalled frame after a release prefix: timeout FERR drops the prefix.
    good(8'hF0);
    send_frame(8'h29, 1'b0, 1'b0, 5, 1'b0);
    push(K_FERR, 8'd0, 1'b0, 1'b0, -1);
    m_rel = 1'b0;
    m_ext = 1'b0;
    tick(2 * TB_TO);
    good(8'h29);
`endif

    // Reset in the middle of a frame, SCLK still low after the 5th fall.
    good(8'hF0);
    send_frame(8'h33, 1'b0, 1'b0, 5, 1'b1);
    tick(2);
    rst_n = 1'b0;
    m_rel  = 1'b0;
    m_ext  = 1'b0;
    m_last = 8'd0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check_data(8'h00);
    sclk = 1'b1;
    tick(10);
    good(8'h29);
    check_data(8'h29);

    // Random key traffic with prefixes, errors and varying SCLK rate.
    repeat (40) begin
      half_per = $urandom_range(3, 6);
      pfx = $urandom_range(0, 3);
      if (pfx == 1 || pfx == 3) good(8'hE0);
      if (pfx == 2 || pfx == 3) good(8'hF0);
      b   = 8'($urandom_range(0, 255));
      err = $urandom_range(0, 9);
      send_frame(b, err == 0, err == 1, 11, 1'b0);
      tick($urandom_range(2, 20));
    end
    half_per = 4;

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
    tb_done = 1'b1;
    tick(5);
    $display("FAIL summary_not_reached");
    $fatal(1);
  end

endmodule
